disp_vramctrl: RTL

AXI4 read master for the display path: fetches one frame of 32-bit pixels from VRAM and writes it, two pixels per 64-bit word, into the display FIFO write port (FIFOIN/FIFOWR) of the display buffer stage. It runs entirely in the ACLK domain, issues fixed-length INCR bursts, and throttles itself on the buffer's BUF_WREADY watermark. Frame fetch starts on a frame-start pulse already synchronised into ACLK.

---
 rtl/disp_vramctrl_if.sv | 27 ++
 rtl/disp_vramctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/disp_vramctrl_if.sv
// AXI4 read-address and read-data channels between the display VRAM fetcher and VRAM.
// Each channel uses valid/ready handshakes. A transfer completes on a rising ACLK edge
// where both valid and ready are high. Valid, and the payload with it, must stay stable
// until that edge. Ready may change freely.
interface disp_vramctrl_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RDATA, RVALID, RLAST, RRESP
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RDATA, RVALID, RLAST, RRESP
    );
endinterface

// File: rtl/disp_vramctrl.sv
// Display VRAM read master: fetches one frame as fixed-length INCR bursts, one burst
// in flight at a time, and forwards every accepted beat to the display FIFO.
module disp_vramctrl #(
    parameter int H_PIX     = 640,
    parameter int V_PIX     = 480,
    parameter int BURST_LEN = 16
) (
    input  logic                   ACLK,
    input  logic                   ARST,
    input  logic                   DISPSTART,
    input  logic                   DISPON,
    input  logic [31:0]            DISPADDR,
    input  logic                   BUF_WREADY,
    disp_vramctrl_if.master        axi,
    output logic [63:0]            FIFOIN,
    output logic                   FIFOWR,
    output logic                   BUSY,
    output logic [1:0]             dbg_state
);
    localparam int FRAME_BURSTS = H_PIX * V_PIX / 2 / BURST_LEN;
    localparam int CNT_W        = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BURST  = CNT_W'(FRAME_BURSTS - 1);
    localparam logic [31:0]      BURST_BYTES = 32'(BURST_LEN * 8);

    typedef enum logic [1:0] {IDLE, WAITBUF, ADDR, DATA} state_t;

    state_t           state;
    logic [31:0]      base;
    logic [31:0]      araddr;
    logic [31:0]      next_addr;
    logic [CNT_W-1:0] burst_cnt;
    logic             arvalid;
    logic             rready;
    logic             unused_rresp;

    // Address arithmetic is deliberately 32-bit so a frame crossing 4 GiB wraps.
    assign next_addr    = base + 32'(burst_cnt) * BURST_BYTES;
    assign unused_rresp = ^axi.RRESP;

    assign axi.ARADDR  = araddr;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'b011;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = arvalid;
    assign axi.RREADY  = rready;
    assign dbg_state   = state;

    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            state     <= IDLE;
            base      <= '0;
            araddr    <= '0;
            burst_cnt <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (DISPSTART && DISPON) begin
                        base      <= DISPADDR;
                        burst_cnt <= '0;
                        BUSY      <= 1'b1;
                        state     <= WAITBUF;
                    end
                end
                WAITBUF: begin
                    if (!DISPON) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (BUF_WREADY) begin
                        araddr  <= next_addr;
                        arvalid <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    // DISPON is not looked at here: an issued request must complete.
                    if (axi.ARREADY) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (axi.RVALID && axi.RLAST) begin
                        rready    <= 1'b0;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == LAST_BURST || !DISPON) begin
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= WAITBUF;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            FIFOIN <= '0;
            FIFOWR <= 1'b0;
        end else begin
            FIFOIN <= axi.RDATA;
            FIFOWR <= axi.RVALID & rready;
        end
    end
endmodule
